// File: rtl/serial_run_pkg.sv
// Shared definitions for the single-bit run-end protocol: FSM encoding and default widths.
// Detector benches import this to decode generator state.
package serial_run_pkg;

    localparam int DEF_LEN_W = 4;
    localparam int GAP_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TERM = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/serial_run_generator_run_len_counter.sv
// Loadable down-counter that tracks the remaining high cycles of a run.
// The FSM only enables it above one, so it never wraps below zero.
module run_len_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] value_i,
    output logic         is_one_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (en_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/serial_run_generator.sv
// Transmit side of the run-end protocol: drives run_len high cycles then one low terminator,
// flagging the terminator on term/done so it can be compared against the detector's W.
module serial_run_generator
    import serial_run_pkg::*;
#(
    parameter int LEN_W      = DEF_LEN_W,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [LEN_W-1:0] run_len,
    input  logic             hold,
    output logic             x_out,
    output logic             term,
    output logic             done,
    output logic             len_err,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    state_t             state_q, state_d;
    logic               x_q, x_d;
    logic               term_q, term_d;
    logic               done_q, done_d;
    logic               len_err_q, len_err_d;
    logic [CNT_W-1:0]   frames_q, frames_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               cnt_load;
    logic               cnt_en;
    logic               cnt_is_one;

    run_len_counter #(
        .W(LEN_W)
    ) u_run_len_counter (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (cnt_load),
        .en_i     (cnt_en),
        .value_i  (run_len),
        .is_one_o (cnt_is_one)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = 1'b0;
        term_d    = 1'b0;
        done_d    = 1'b0;
        len_err_d = 1'b0;
        frames_d  = frames_q;
        gap_d     = gap_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    if (run_len != '0) begin
                        state_d  = RUN;
                        x_d      = 1'b1;
                        cnt_load = 1'b1;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // hold stretches the run: line stays high and the counter is frozen
                x_d = 1'b1;
                if (!hold) begin
                    if (cnt_is_one) begin
                        state_d  = TERM;
                        x_d      = 1'b0;
                        term_d   = 1'b1;
                        done_d   = 1'b1;
                        frames_d = frames_q + 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            TERM: begin
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= 1'b0;
            term_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            frames_q  <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            term_q    <= term_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
            frames_q  <= frames_d;
            gap_q     <= gap_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign x_out       = x_q;
    assign term        = term_q;
    assign done        = done_q;
    assign len_err     = len_err_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_serial_run_generator.sv
// Directed bench for serial_run_generator: three instances cover GAP=1, GAP=0 and a 2-bit frame counter.
module tb_serial_run_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // instance a: defaults (GAP_CYCLES=1, CNT_W=8)
    logic       a_sv = 1'b0, a_hold = 1'b0;
    logic [3:0] a_len = 4'd0;
    logic       a_rdy, a_x, a_term, a_done, a_lerr, a_busy;
    logic [7:0] a_fr;
    // instance b: GAP_CYCLES=0
    logic       b_sv = 1'b0, b_hold = 1'b0;
    logic [3:0] b_len = 4'd0;
    logic       b_rdy, b_x, b_term, b_done, b_lerr, b_busy;
    logic [7:0] b_fr;
    // instance c: CNT_W=2
    logic       c_sv = 1'b0, c_hold = 1'b0;
    logic [3:0] c_len = 4'd0;
    logic       c_rdy, c_x, c_term, c_done, c_lerr, c_busy;
    logic [1:0] c_fr;

    serial_run_generator dut_a (
        .clk(clk), .rst(rst), .start_valid(a_sv), .start_ready(a_rdy), .run_len(a_len),
        .hold(a_hold), .x_out(a_x), .term(a_term), .done(a_done), .len_err(a_lerr),
        .busy(a_busy), .frames_sent(a_fr)
    );
    serial_run_generator #(.GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start_valid(b_sv), .start_ready(b_rdy), .run_len(b_len),
        .hold(b_hold), .x_out(b_x), .term(b_term), .done(b_done), .len_err(b_lerr),
        .busy(b_busy), .frames_sent(b_fr)
    );
    serial_run_generator #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .start_valid(c_sv), .start_ready(c_rdy), .run_len(c_len),
        .hold(c_hold), .x_out(c_x), .term(c_term), .done(c_done), .len_err(c_lerr),
        .busy(c_busy), .frames_sent(c_fr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({a_x, a_term, a_done, a_lerr, a_busy, a_rdy, a_fr} !== {5'b0, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL reset_a got %b required %b", {a_x, a_term, a_done, a_lerr, a_busy, a_rdy, a_fr}, {5'b0, 1'b1, 8'd0});
        end
        vectors++;
        if ({b_x, b_term, b_done, b_lerr, b_busy, b_rdy, b_fr} !== {5'b0, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL reset_b got %b required %b", {b_x, b_term, b_done, b_lerr, b_busy, b_rdy, b_fr}, {5'b0, 1'b1, 8'd0});
        end
        vectors++;
        if ({c_x, c_term, c_done, c_lerr, c_busy, c_rdy, c_fr} !== {5'b0, 1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_c got %b required %b", {c_x, c_term, c_done, c_lerr, c_busy, c_rdy, c_fr}, {5'b0, 1'b1, 2'd0});
        end
        rst = 1'b0;
        step();
    endtask

    // run_len=3 accepted at T: high T+1..T+3, terminator T+4, ready again T+6
    task automatic test_basic_run();
        logic [3:0] exp_x;
        logic [3:0] exp_t;
        exp_x = 4'b0111;
        exp_t = 4'b1000;
        a_sv = 1'b1;
        a_len = 4'd3;
        step();
        a_sv = 1'b0;
        a_len = 4'd9;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({a_x, a_term, a_done, a_busy} !== {exp_x[k], exp_t[k], exp_t[k], 1'b1}) begin
                miscompares++;
                $display("FAIL basic_cyc%0d x/term/done/busy got %b required %b", k + 1,
                         {a_x, a_term, a_done, a_busy}, {exp_x[k], exp_t[k], exp_t[k], 1'b1});
            end
            if (k < 3) step();
        end
        vectors++;
        if (a_fr !== 8'd1) begin
            miscompares++;
            $display("FAIL basic_frames got %0d required 1", a_fr);
        end
        step();
        vectors++;
        if ({a_rdy, a_x, a_term} !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_gap rdy/x/term got %b required 000", {a_rdy, a_x, a_term});
        end
        step();
        vectors++;
        if ({a_rdy, a_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_ready rdy/busy got %b required 10", {a_rdy, a_busy});
        end
    endtask

    task automatic test_zero_len();
        a_sv = 1'b1;
        a_len = 4'd0;
        step();
        a_sv = 1'b0;
        vectors++;
        if ({a_lerr, a_busy, a_x, a_fr} !== {3'b100, 8'd1}) begin
            miscompares++;
            $display("FAIL zero_len lerr/busy/x/frames got %b required %b", {a_lerr, a_busy, a_x, a_fr}, {3'b100, 8'd1});
        end
        step();
        vectors++;
        if ({a_lerr, a_busy, a_x, a_fr} !== {3'b000, 8'd1}) begin
            miscompares++;
            $display("FAIL zero_len_after lerr/busy/x/frames got %b required %b", {a_lerr, a_busy, a_x, a_fr}, {3'b000, 8'd1});
        end
    endtask

    // run_len=2, hold high in cycles T+2..T+4: five high cycles, terminator at T+6
    task automatic test_hold();
        logic [7:0] exp_x;
        logic [7:0] exp_t;
        int terms;
        exp_x = 8'b0011_1110;
        exp_t = 8'b0100_0000;
        terms = 0;
        a_sv = 1'b1;
        a_len = 4'd2;
        step();
        a_sv = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            vectors++;
            if ({a_x, a_term} !== {exp_x[k], exp_t[k]}) begin
                miscompares++;
                $display("FAIL hold_cyc%0d x/term got %b required %b", k, {a_x, a_term}, {exp_x[k], exp_t[k]});
            end
            if (a_term === 1'b1) terms++;
            a_hold = (k >= 2 && k <= 4);
            step();
        end
        a_hold = 1'b0;
        vectors++;
        if (terms != 1 || a_fr !== 8'd2) begin
            miscompares++;
            $display("FAIL hold_terms terms=%0d frames=%0d required 1 and 2", terms, a_fr);
        end
    endtask

    task automatic test_max_len();
        int highs;
        bit seen_term;
        highs = 0;
        seen_term = 1'b0;
        b_sv = 1'b1;
        b_len = 4'd15;
        step();
        b_sv = 1'b0;
        for (int k = 0; k < 20 && !seen_term; k++) begin
            if (b_term === 1'b1) seen_term = 1'b1;
            else begin
                if (b_x === 1'b1) highs++;
                step();
            end
        end
        vectors++;
        if (!seen_term || highs != 15 || b_x !== 1'b0 || b_fr !== 8'd1) begin
            miscompares++;
            $display("FAIL max_len term=%0d highs=%0d x=%b frames=%0d required 1 15 0 1", seen_term, highs, b_x, b_fr);
        end
        step();
    endtask

    // GAP=0, run_len=1 held valid: second accept lands on the idle cycle right after TERM
    task automatic test_back_to_back();
        logic [7:0] exp_x;
        logic [7:0] exp_d;
        int dones;
        exp_x = 8'b0000_1001;
        exp_d = 8'b0001_0010;
        dones = 0;
        b_sv = 1'b1;
        b_len = 4'd1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 3) b_sv = 1'b0;
            if (k == 1) begin
                vectors++;
                if (b_rdy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_ready_in_term got %b required 0", b_rdy);
                end
            end
            vectors++;
            if ({b_x, b_done} !== {exp_x[k], exp_d[k]}) begin
                miscompares++;
                $display("FAIL b2b_cyc%0d x/done got %b required %b", k + 1, {b_x, b_done}, {exp_x[k], exp_d[k]});
            end
            if (b_done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 2 || b_fr !== 8'd3) begin
            miscompares++;
            $display("FAIL b2b_dones got %0d frames %0d required 2 and 3", dones, b_fr);
        end
    endtask

    task automatic test_reset_mid_run();
        a_sv = 1'b1;
        a_len = 4'd15;
        step();
        a_sv = 1'b0;
        step();
        step();
        vectors++;
        if ({a_x, a_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL midrst_running x/busy got %b required 11", {a_x, a_busy});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({a_x, a_term, a_done, a_busy, a_rdy, a_fr} !== {5'b00001, 8'd0}) begin
            miscompares++;
            $display("FAIL midrst_abort got %b required %b", {a_x, a_term, a_done, a_busy, a_rdy, a_fr}, {5'b00001, 8'd0});
        end
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if ({a_x, a_done, a_fr} !== {2'b00, 8'd0}) begin
                miscompares++;
                $display("FAIL midrst_quiet%0d x/done/frames got %b required 0", k, {a_x, a_done, a_fr});
            end
        end
    endtask

    // CNT_W=2: frame count wraps 1,2,3,0,1; loopback W = prev_x & ~x must equal term
    task automatic test_wrap_loopback();
        logic [1:0] exp_fr;
        logic prev_x;
        logic w;
        for (int f = 0; f < 5; f++) begin
            prev_x = c_x;
            c_sv = 1'b1;
            c_len = 4'd1;
            step();
            c_sv = 1'b0;
            for (int cyc = 1; cyc <= 4; cyc++) begin
                if (cyc > 1) step();
                w = prev_x & ~c_x;
                vectors++;
                if (w !== c_term) begin
                    miscompares++;
                    $display("FAIL loopback_f%0d_c%0d term got %b required %b", f, cyc, c_term, w);
                end
                if (cyc == 2) begin
                    exp_fr = 2'(f + 1);
                    vectors++;
                    if ({c_term, c_fr} !== {1'b1, exp_fr}) begin
                        miscompares++;
                        $display("FAIL wrap_f%0d term/frames got %b required %b", f, {c_term, c_fr}, {1'b1, exp_fr});
                    end
                end
                prev_x = c_x;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_zero_len();
        test_hold();
        test_max_len();
        test_back_to_back();
        test_reset_mid_run();
        test_wrap_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
